seven_seg_scan_ctrl: RTL and testbench
======================================

Name: seven_seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for a NUM_DIGITS common-anode seven-segment display.
- Sits directly upstream of the binary-to-seven-segment gate-level decoder.
- Each refresh period it selects one digit, presents that digit's 4-bit value to the decoder, and drives the matching active-low anode.
- New display values come in through a valid/ready handshake and take effect only at frame boundaries, so the display never tears.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (2..8)
REFRESH_CYCLES, 50000, clk cycles each digit is lit (>=2)
CNT_W, 16, refresh counter width; must satisfy 2^CNT_W >= REFRESH_CYCLES

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
in_val  input  1  new display word valid
in_rdy  output  1  controller can accept a new display word
in_digits  input  4*NUM_DIGITS  packed nibbles, digit 0 in [3:0]
in_dp  input  NUM_DIGITS  decimal-point enables, bit i for digit i
en  input  1  display enable; 0 blanks and freezes scanning
lzs  input  1  leading-zero suppression enable
dig  output  4  nibble of selected digit, to decoder input
dp  output  1  decimal point of selected digit, active-high
an_n  output  NUM_DIGITS  anode selects, active-low, at most one low
frame_start  output  1  one-cycle pulse when digit 0 becomes lit

Behaviour:
- Reset (async assert, sync-safe release) sets:
  - cnt=0, idx=NUM_DIGITS-1, active word=0, active dp=0, pending flag=0.
  - an_n=all 1s, dig=0, dp=0, frame_start=0, in_rdy=1.
- Refresh counter:
  - While en=1, cnt increments each cycle.
  - tick is asserted when cnt==REFRESH_CYCLES-1; cnt wraps to 0 on tick.
  - While en=0, cnt and idx hold, and an_n is driven all 1s on the next cycle.
- Digit index:
  - On tick, idx advances by 1 and wraps NUM_DIGITS-1 -> 0.
  - A frame boundary is a tick with idx==NUM_DIGITS-1.
  - Because idx resets to NUM_DIGITS-1, the first tick after reset is a frame boundary.
- Handshake:
  - A transfer occurs when in_val && in_rdy. in_digits and in_dp are captured into the pending register, the pending flag is set, and in_rdy drops the next cycle.
  - in_rdy = !pending. in_val may be held without a transfer and does not need to stay stable while in_rdy=0.
- Frame update:
  - At a frame boundary with pending=1, pending is copied to the active word and the pending flag clears. in_rdy rises the next cycle.
  - A transfer and a frame boundary in the same cycle: the transfer goes to pending; the previous pending value, if any, is applied to active that cycle.
- Outputs (registered, 1-cycle latency from tick):
  - The cycle after tick, the outputs reflect the new idx.
  - an_n[idx]=0, all other bits 1.
  - dig = active[4*idx +: 4].
  - dp = active_dp[idx].
  - frame_start=1 when the new idx==0.
- Leading-zero suppression:
  - With lzs=1, digit i (i>0) is blanked when digit i and every higher digit in the active word are 0.
  - Blanked means an_n all 1s, dig=0, dp=0. Digit 0 is never blanked.
  - lzs is sampled combinationally in the output register path every cycle.
- Blanking behaviour:
  - frame_start still pulses when digit 0 is selected, even if outputs are blanked by lzs.
  - frame_start never pulses while en=0.
- Reset mid-operation clears the pending word; a word in flight is discarded.

Test Plan:
- Reset, REFRESH_CYCLES=4, en=1, no input -> an_n=1111 until the first tick at cycle 4; then an_n=1110 with dig=0, and frame_start pulses once.
- Send in_digits=0x4321, in_dp=0100 -> applied at the next frame boundary. Scanning yields dig 1,2,3,4 with an_n 1110,1101,1011,0111, each held 4 cycles; dp=1 only while an_n=1011.
- Send 0x1111 then hold in_val with 0x2222 before the boundary -> in_rdy=0 until the boundary, then 0x2222 is accepted. 0x1111 is displayed for exactly one full frame before 0x2222 appears.
- Active=0x0050, lzs=1 -> digits 3 and 2 are blank (an_n=1111); digit 1 shows 5; digit 0 shows 0. With lzs=0, all four digits are lit.
- en=0 for 10 cycles mid-digit-2 -> an_n=1111, cnt and idx frozen, no frame_start. Re-enable -> digit 2 resumes with its remaining count.
- Assert rst_n=0 mid-scan with pending=1 -> outputs blank immediately and in_rdy=1. After release, active=0 and the old pending word never appears.

Source files
------------

// File: rtl/seven_seg_scan_ctrl_if.sv
// Display-word handshake bundle for seven_seg_scan_ctrl.
//   in_val    : producer has a new display word
//   in_rdy    : controller can accept a new display word
//   in_digits : packed nibbles, digit 0 in [3:0]
//   in_dp     : decimal-point enables, bit i for digit i
// master = producer of display words, slave = scan controller.
interface seven_seg_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
);
  logic                      in_val;
  logic                      in_rdy;
  logic [4*NUM_DIGITS-1:0]   in_digits;
  logic [NUM_DIGITS-1:0]     in_dp;

  modport master (output in_val, output in_digits, output in_dp, input in_rdy);
  modport slave  (input in_val, input in_digits, input in_dp, output in_rdy);
endinterface

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode seven-segment display.
// Lights one digit per refresh period, feeding its nibble to the downstream
// binary-to-seven-segment decoder and pulling its anode low.
// Ports:
//   clk, rst_n  : system clock, asynchronous active-low reset
//   in_if       : display-word handshake (slave side)
//   en          : display enable; 0 blanks and freezes scanning
//   lzs         : leading-zero suppression enable
//   dig, dp     : nibble and decimal point of the lit digit
//   an_n        : active-low anode selects, at most one low
//   frame_start : one-cycle pulse when digit 0 becomes lit
module seven_seg_scan_ctrl #(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_CYCLES = 50000,
  parameter int CNT_W          = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  seven_seg_scan_ctrl_if.slave  in_if,
  input  logic                  en,
  input  logic                  lzs,
  output logic [3:0]            dig,
  output logic                  dp,
  output logic [NUM_DIGITS-1:0] an_n,
  output logic                  frame_start
);

  localparam int                IDX_W    = $clog2(NUM_DIGITS);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(REFRESH_CYCLES - 1);

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] act_q, act_d;
  logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d;
  logic [4*NUM_DIGITS-1:0] pend_q, pend_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic                    pend_vld_q, pend_vld_d;
  logic                    started_q, started_d;
  logic [NUM_DIGITS-1:0]   an_n_q, an_n_d;
  logic [3:0]              dig_q, dig_d;
  logic                    dp_q, dp_d;
  logic                    fs_q, fs_d;

  logic                    tick;
  logic                    frame_bnd;
  logic                    xfer;
  logic                    zero_run;
  logic [NUM_DIGITS-1:0]   lead_zero;
  logic                    blank;

  always_comb begin
    tick      = en && (cnt_q == CNT_LAST);
    frame_bnd = tick && (idx_q == IDX_LAST);
    xfer      = in_if.in_val && !pend_vld_q;

    cnt_d = cnt_q;
    if (en) cnt_d = tick ? '0 : cnt_q + 1'b1;

    idx_d = idx_q;
    if (tick) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;

    // The pending word is only promoted on a frame boundary so the display
    // never shows a mix of old and new digits. A transfer can only land when
    // nothing is pending, so it never collides with a promotion.
    act_d      = act_q;
    act_dp_d   = act_dp_q;
    pend_d     = pend_q;
    pend_dp_d  = pend_dp_q;
    pend_vld_d = pend_vld_q;
    if (frame_bnd && pend_vld_q) begin
      act_d      = pend_q;
      act_dp_d   = pend_dp_q;
      pend_vld_d = 1'b0;
    end
    if (xfer) begin
      pend_d     = in_if.in_digits;
      pend_dp_d  = in_if.in_dp;
      pend_vld_d = 1'b1;
    end

    // Outputs stay dark until the first tick after reset selects digit 0.
    started_d = started_q | tick;

    // lead_zero[i]: digit i and every digit above it are zero.
    zero_run  = 1'b1;
    lead_zero = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run     = zero_run & (act_d[4*i +: 4] == 4'd0);
      lead_zero[i] = zero_run;
    end

    blank = !en || !started_d || (lzs && (idx_d != '0) && lead_zero[idx_d]);

    an_n_d = '1;
    dig_d  = 4'd0;
    dp_d   = 1'b0;
    if (!blank) begin
      an_n_d[idx_d] = 1'b0;
      dig_d         = act_d[4*idx_d +: 4];
      dp_d          = act_dp_d[idx_d];
    end

    // Pulses even when digit 0 is blanked; tick already implies en.
    fs_d = tick && (idx_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      idx_q      <= IDX_LAST;
      act_q      <= '0;
      act_dp_q   <= '0;
      pend_q     <= '0;
      pend_dp_q  <= '0;
      pend_vld_q <= 1'b0;
      started_q  <= 1'b0;
      an_n_q     <= '1;
      dig_q      <= 4'd0;
      dp_q       <= 1'b0;
      fs_q       <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      act_q      <= act_d;
      act_dp_q   <= act_dp_d;
      pend_q     <= pend_d;
      pend_dp_q  <= pend_dp_d;
      pend_vld_q <= pend_vld_d;
      started_q  <= started_d;
      an_n_q     <= an_n_d;
      dig_q      <= dig_d;
      dp_q       <= dp_d;
      fs_q       <= fs_d;
    end
  end

  assign in_if.in_rdy = !pend_vld_q;
  assign an_n         = an_n_q;
  assign dig          = dig_q;
  assign dp           = dp_q;
  assign frame_start  = fs_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl with a 4-cycle refresh period.
module tb_seven_seg_scan_ctrl;

  localparam int ND = 4;

  logic          clk;
  logic          rst_n;
  logic          en;
  logic          lzs;
  logic [3:0]    dig;
  logic          dp;
  logic [ND-1:0] an_n;
  logic          frame_start;

  int n_tests;
  int n_fail;

  logic [3:0] e_an_lzs  [4];
  logic [3:0] e_dig_lzs [4];

  seven_seg_scan_ctrl_if #(.NUM_DIGITS(ND)) bus ();

  seven_seg_scan_ctrl #(
    .NUM_DIGITS     (ND),
    .REFRESH_CYCLES (4),
    .CNT_W          (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_if       (bus),
    .en          (en),
    .lzs         (lzs),
    .dig         (dig),
    .dp          (dp),
    .an_n        (an_n),
    .frame_start (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_fs(input string tag);
    int n;
    n = 0;
    while (!frame_start && n < 64) begin
      step();
      n++;
    end
    check(tag, frame_start, 1);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    e_an_lzs[0]  = 4'b1110; e_dig_lzs[0] = 4'd0;
    e_an_lzs[1]  = 4'b1101; e_dig_lzs[1] = 4'd5;
    e_an_lzs[2]  = 4'b1111; e_dig_lzs[2] = 4'd0;
    e_an_lzs[3]  = 4'b1111; e_dig_lzs[3] = 4'd0;

    bus.in_val    = 1'b0;
    bus.in_digits = '0;
    bus.in_dp     = '0;
    en    = 1'b1;
    lzs   = 1'b0;
    rst_n = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_an", an_n, 4'b1111);
    check("rst_dig", dig, 0);
    check("rst_dp", dp, 0);
    check("rst_fs", frame_start, 0);
    check("rst_rdy", bus.in_rdy, 1);
    rst_n = 1'b1;

    // First tick lands on the 4th edge after release
    for (int k = 1; k <= 3; k++) begin
      step();
      check("pre_tick_an", an_n, 4'b1111);
      check("pre_tick_fs", frame_start, 0);
    end
    step();
    check("tick1_an", an_n, 4'b1110);
    check("tick1_fs", frame_start, 1);
    check("tick1_dig", dig, 0);
    step();
    check("tick1_fs_pulse", frame_start, 0);

    // 0x4321 with dp on digit 2
    bus.in_digits = 16'h4321;
    bus.in_dp     = 4'b0100;
    bus.in_val    = 1'b1;
    step();
    bus.in_val = 1'b0;
    check("w4321_rdy_low", bus.in_rdy, 0);
    wait_fs("w4321_fs");
    check("w4321_rdy_back", bus.in_rdy, 1);
    for (int d = 0; d < 4; d++) begin
      for (int c = 0; c < 4; c++) begin
        check("scan_an", an_n, 4'b1111 ^ (4'b0001 << d));
        check("scan_dig", dig, d + 1);
        check("scan_dp", dp, (d == 2) ? 1 : 0);
        step();
      end
    end
    check("scan_wrap_fs", frame_start, 1);

    // 0x1111 then 0x2222 held on in_val
    bus.in_digits = 16'h1111;
    bus.in_dp     = 4'b0000;
    bus.in_val    = 1'b1;
    step();
    bus.in_digits = 16'h2222;
    check("hold_rdy_low", bus.in_rdy, 0);
    wait_fs("w1111_fs");
    check("w1111_dig0", dig, 1);
    check("w1111_rdy_up", bus.in_rdy, 1);
    step();
    bus.in_val = 1'b0;
    check("w2222_taken", bus.in_rdy, 0);
    for (int c = 1; c < 16; c++) begin
      check("w1111_frame_dig", dig, 1);
      step();
    end
    check("w2222_fs", frame_start, 1);
    check("w2222_dig0", dig, 2);

    // 0x0050 with leading-zero suppression
    bus.in_digits = 16'h0050;
    bus.in_dp     = 4'b0000;
    bus.in_val    = 1'b1;
    lzs           = 1'b1;
    step();
    bus.in_val = 1'b0;
    wait_fs("w0050_fs");
    for (int d = 0; d < 4; d++) begin
      for (int c = 0; c < 4; c++) begin
        if (c == 1) begin
          check("lzs_an", an_n, e_an_lzs[d]);
          check("lzs_dig", dig, e_dig_lzs[d]);
        end
        step();
      end
    end
    lzs = 1'b0;
    for (int d = 0; d < 4; d++) begin
      for (int c = 0; c < 4; c++) begin
        if (c == 1) begin
          check("nolzs_an", an_n, 4'b1111 ^ (4'b0001 << d));
          check("nolzs_dig", dig, (d == 1) ? 5 : 0);
        end
        step();
      end
    end
    check("nolzs_wrap_fs", frame_start, 1);

    // Freeze mid digit 2
    repeat (9) step();
    check("pre_freeze_an", an_n, 4'b1011);
    en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      check("freeze_an", an_n, 4'b1111);
      check("freeze_fs", frame_start, 0);
      check("freeze_dig", dig, 0);
    end
    en = 1'b1;
    step();
    check("resume_an1", an_n, 4'b1011);
    step();
    check("resume_an2", an_n, 4'b1011);
    step();
    check("resume_an3", an_n, 4'b0111);

    // Reset with a word pending
    bus.in_digits = 16'h9876;
    bus.in_dp     = 4'b1111;
    bus.in_val    = 1'b1;
    step();
    bus.in_val = 1'b0;
    check("pend_rdy_low", bus.in_rdy, 0);
    rst_n = 1'b0;
    #2;
    check("midrst_an", an_n, 4'b1111);
    check("midrst_rdy", bus.in_rdy, 1);
    check("midrst_dig", dig, 0);
    check("midrst_fs", frame_start, 0);
    rst_n = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      check("post_rst_an", an_n, 4'b1111);
    end
    step();
    check("post_rst_fs", frame_start, 1);
    for (int d = 0; d < 4; d++) begin
      for (int c = 0; c < 4; c++) begin
        check("post_rst_scan_an", an_n, 4'b1111 ^ (4'b0001 << d));
        check("post_rst_dig", dig, 0);
        check("post_rst_dp", dp, 0);
        step();
      end
    end
    check("post_rst_wrap_dig", dig, 0);
    check("post_rst_wrap_rdy", bus.in_rdy, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
